// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side bundle of the UART receive FIFO.
//   master : consumer (mmio load path) - drives rd_en, clr_err
//   slave  : uart_rx_fifo             - drives rd_data, empty, full, count,
//                                       frame_err, overrun
// FIFO_DEPTH must match the uart_rx_fifo instance so that count is sized alike.
interface uart_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic            rd_en;
    logic            clr_err;
    logic [7:0]      rd_data;
    logic            empty;
    logic            full;
    logic [CntW-1:0] count;
    logic            frame_err;
    logic            overrun;

    modport master (
        output rd_en, clr_err,
        input  rd_data, empty, full, count, frame_err, overrun
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, empty, full, count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO with sticky
// frame/overrun error flags. Single clock domain (CLK100MHZ).
// Ports:
//   CLK100MHZ  in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   rx         in   asynchronous serial line, idles high
//   bus        slave modport of uart_rx_fifo_if (rd_en, clr_err in;
//              rd_data, empty, full, count, frame_err, overrun out)
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic          CLK100MHZ,
    input  logic          rst_n,
    input  logic          rx,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] FullM1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfM1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    sync_q;
    logic          rxs;
    logic          push, stop_bad;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic          empty_w, full_w, pop, push_ok, drop;
    logic          frame_err_q, overrun_q;

    assign rxs = sync_q[1];

    // Receive FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfM1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is already high again mid-bit was a glitch.
                    state_d = rxs ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StData: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (cnt_q == FullM1) begin
                    cnt_d    = '0;
                    // Back to idle mid-stop-bit so a following start edge is caught.
                    state_d  = StIdle;
                    push     = rxs;
                    stop_bad = !rxs;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sync_q  <= {sync_q[0], rx};
        end
    end

    // FIFO
    assign empty_w = (wr_q == rd_q);
    assign full_w  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = bus.rd_en && !empty_w;
    // When full, a same-cycle pop frees the slot the push needs.
    assign push_ok = push && (!full_w || pop);
    assign drop    = push && full_w && !pop;

    always_ff @(posedge CLK100MHZ) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= shift_q;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + (AW+1)'(1);
            if (pop)     rd_q <= rd_q + (AW+1)'(1);
            // Set wins over clear.
            frame_err_q <= (frame_err_q && !bus.clr_err) || stop_bad;
            overrun_q   <= (overrun_q && !bus.clr_err) || drop;
        end
    end

    assign bus.rd_data   = empty_w ? 8'h00 : mem_q[rd_q[AW-1:0]];
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.count     = wr_q - rd_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int unsigned CPB   = 32;
    localparam int unsigned DEPTH = 8;
    localparam int          FRAME = 10 * CPB;
    // Falling start edge to push: 2 + CPB/2 + 9*CPB
    localparam int          LAT   = 2 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .CLK_HZ     (CPB * 3125000),
        .BAUD       (3125000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK100MHZ (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Byte-level reference model
    logic [7:0] q[$];
    bit         m_ferr = 1'b0;
    bit         m_ovr  = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == DEPTH));
        chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
        chk({tag, ".rd_data"}, 32'(bus.rd_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
        chk({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop_one(input string tag);
        if (q.size() > 0) chk({tag, ".head"}, 32'(bus.rd_data), 32'(q[0]));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_state(tag);
    endtask

    task automatic clear_err();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Drive one frame. pop_at/rst_at give the bit-time offset (cycles after the
    // start edge) at which rd_en is pulsed / reset is asserted; -1 disables.
    // fall reports cycles from start edge to empty first seen low.
    task automatic send(input logic [7:0] b, input bit stop_ok, input int pop_at,
                        input int rst_at, output int fall);
        logic [9:0] frm;
        bit         aborted;
        frm     = {stop_ok, b, 1'b0};
        fall    = -1;
        aborted = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            rx        = frm[c / CPB];
            bus.rd_en = (c == pop_at);
            if (c == pop_at && q.size() > 0)
                chk("pop_on_push.head", 32'(bus.rd_data), 32'(q[0]));
            if (c == rst_at) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            if (c == rst_at) begin
                aborted = 1'b1;
                break;
            end
            if (fall < 0 && !bus.empty) fall = c + 1;
        end
        bus.rd_en = 1'b0;
        rx        = 1'b1;
        if (aborted) begin
            q.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            if (pop_at >= 0 && q.size() > 0) void'(q.pop_front());
            if (!stop_ok)              m_ferr = 1'b1;
            else if (q.size() < DEPTH) q.push_back(b);
            else                       m_ovr = 1'b1;
            // Keep the line high after a low stop bit so it is not read as a start.
            if (!stop_ok) idle(2 * CPB);
        end
    endtask

    task automatic send_ok(input logic [7:0] b);
        int f;
        send(b, 1'b1, -1, -1, f);
    endtask

    initial begin
        int f;
        logic [7:0] r;
        rst_n       = 1'b0;
        rx          = 1'b1;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_state("reset");

        // Single byte with latency check
        send(8'h55, 1'b1, -1, -1, f);
        chk("latency_window", 32'(f >= LAT - 3 && f <= LAT + 3), 32'd1);
        check_state("single");
        pop_one("single_pop");

        // Back-to-back frames
        send_ok(8'hA3);
        send_ok(8'h00);
        send_ok(8'hFF);
        check_state("b2b");
        repeat (3) pop_one("b2b_pop");

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (CPB / 3) tick();
        idle(2 * FRAME);
        check_state("glitch");
        send_ok(8'h3C);
        check_state("after_glitch");
        pop_one("after_glitch_pop");

        // Framing error then clear
        send(8'h81, 1'b0, -1, -1, f);
        check_state("frame_err");
        clear_err();
        check_state("frame_err_clr");

        // Overrun: nine bytes into eight slots
        for (int i = 1; i <= 9; i++) send_ok(8'(i));
        check_state("overrun");
        repeat (DEPTH) pop_one("overrun_pop");
        clear_err();
        for (int i = 0; i < 4; i++) send_ok(8'hE0 + 8'(i));
        check_state("refill");
        repeat (4) pop_one("refill_pop");

        // Pop on the exact push cycle while full
        for (int i = 0; i < DEPTH; i++) send_ok(8'($urandom_range(0, 255)));
        check_state("prefull");
        send(8'hC7, 1'b1, LAT, -1, f);
        check_state("pop_on_push");
        repeat (DEPTH) pop_one("pop_on_push_drain");

        // Reset during data bit 4
        send_ok(8'h11);
        send(8'h22, 1'b0, -1, -1, f);
        check_state("pre_reset");
        send(8'h96, 1'b1, -1, 5 * CPB + CPB / 3, f);
        check_state("mid_reset");
        idle(FRAME);
        check_state("post_reset_idle");
        send_ok(8'h5A);
        check_state("after_reset");
        pop_one("after_reset_pop");

        // Random traffic across pointer wraps
        for (int i = 0; i < 14; i++) begin
            r = 8'($urandom_range(0, 255));
            send(r, ($urandom_range(0, 7) != 0), -1, -1, f);
            check_state("rand");
            repeat ($urandom_range(0, 2)) pop_one("rand_pop");
            if ($urandom_range(0, 3) == 0) begin
                clear_err();
                check_state("rand_clr");
            end
        end
        while (q.size() > 0) pop_one("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receive path for the SoC: deserialises 8N1 frames arriving on the board's `uart_txd_in` pin.
- Buffers received bytes in a small FIFO and presents them to the mmio load path through a show-ahead read interface with sticky error flags.
- Complements the existing transmit path on `uart_rxd_out`; runs entirely in the `CLK100MHZ` domain.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated (868 at defaults).
- FIFO_DEPTH, 8, number of byte entries; must be a power of two, at least 2.

Ports:
- `CLK100MHZ`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `rx`  in  1  asynchronous serial input (board `uart_txd_in`); idles high.
- `rd_en`  in  1  pop the head byte; ignored when `empty`=1.
- `clr_err`  in  1  clears `frame_err` and `overrun`.
- `rd_data`  out  8  head byte (show-ahead); 0 when empty.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds FIFO_DEPTH bytes.
- `count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `frame_err`  out  1  sticky: a frame's stop bit sampled low.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- **Reset** (`rst_n`=0 at a clock edge):
  - FSM goes to IDLE; bit counter and baud counter clear.
  - FIFO pointers clear, so `empty`=1, `full`=0, `count`=0, `rd_data`=0.
  - `frame_err`=0, `overrun`=0.
  - Synchroniser flops are set to 1.
  - Reset mid-frame abandons the frame; nothing is pushed.
- **Input synchroniser:** 2-flop synchroniser on `rx`. All sampling uses the synchronised value `rxs`, which carries 2 cycles of latency.
- **FSM states:**
  - IDLE: baud counter held at 0. Go to START when `rxs`=0.
  - START: count CLKS_PER_BIT/2 cycles, then sample `rxs`. If 0, go to DATA with the baud counter cleared and bit index 0. If 1 (glitch), return to IDLE; no flag is set.
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into the shift register, LSB first. After bit index 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - `rxs`=1: assert an internal push for exactly one cycle.
    - `rxs`=0: no push; set `frame_err`.
    - In both cases return to IDLE on the next cycle, so a back-to-back start bit is detected immediately.
- **Push:**
  - Not full: write the byte at the write pointer and increment the pointer.
  - Full and `rd_en`=0: drop the byte and set `overrun`.
  - Full and `rd_en`=1 in the same cycle: the pop frees a slot and the push succeeds; `overrun` is not set.
- **Pop:** `rd_en`=1 with `empty`=0 advances the read pointer. `rd_data` shows the new head on the following cycle.
- **Simultaneous push and pop when not empty:** `count` is unchanged.
- **Push into an empty FIFO:** `empty` deasserts and `rd_data` is valid on the cycle after the push.
- **Pointers:** log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH.
  - `full` = (MSBs differ, low bits equal).
  - `empty` = (pointers equal).
  - `count` = wr_ptr - rd_ptr.
- **Error flags:** remain set until `clr_err`=1 or reset. If `clr_err` coincides with a new error event, the flag stays set (set wins).
- **Latency:** start-bit falling edge on `rx` to push is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, ±1. At defaults this is 8248 cycles.

Test Plan:
- **Single byte:** reset, then drive frame 0x55 at 868 cycles/bit. Require:
  - `empty` falls within 8248±3 cycles.
  - `rd_data`=0x55 and `count`=1.
  - After a 1-cycle `rd_en`: `empty`=1, `count`=0.
- **Back-to-back bytes:** send 0xA3, 0x00, 0xFF with no idle gap. Require `count`=3 and pops return 0xA3, 0x00, 0xFF in order, with no errors.
- **Glitch rejection:** a 300-cycle low pulse on `rx`. Require no push, `empty`=1, `frame_err`=0. A valid frame 0x3C afterwards is then received correctly.
- **Framing error:** send 0x81 with the stop bit low. Require no push, `frame_err`=1. Then `clr_err`=1 for one cycle gives `frame_err`=0.
- **Overrun and wrap:**
  - Send 9 bytes 0x01..0x09 without reading. Require `full`=1, `count`=8, `overrun`=1; pops return 0x01..0x08.
  - Refill 4 bytes to cross the pointer wrap; require pops return the correct bytes.
  - Separately, assert `rd_en` on the exact push cycle while full. Require `overrun` stays 0 and `count` stays 8.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during data bit 4 of a frame. Require all outputs at reset values, that frame is not pushed, and the next full frame 0x5A is received correctly.
